// File: rtl/tile_seq_pkg.sv
// Shared types and default sizing for the tile sequencer.
package tile_seq_pkg;

    localparam int N_TILES_MAX_DEF = 64;
    localparam int MAX_OUT_DEF     = 4;
    localparam int TIMEOUT_DEF     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } seqState_e;

endpackage

// File: rtl/tile_seq_ctrl_if.sv
// Tile-start handshake and per-tile retire strobe between sequencer and MAC datapath.
interface tile_seq_ctrl_if
    import tile_seq_pkg::*;
#(
    parameter int CNT_W = $clog2(N_TILES_MAX_DEF + 1)
) ();

    logic             tile_TVALID;
    logic             tile_TREADY;
    logic [CNT_W-1:0] tile_TIDX;
    logic             y_fire;

    modport master (
        output tile_TVALID,
        output tile_TIDX,
        input  tile_TREADY,
        input  y_fire
    );

    modport slave (
        input  tile_TVALID,
        input  tile_TIDX,
        output tile_TREADY,
        output y_fire
    );

endinterface

// File: rtl/tile_seq_wdog.sv
// Saturating idle watchdog: cleared by activity, counts while enabled, flags expiry.
module tile_seq_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over counting; the count saturates at the limit so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + W'(1);
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LIMIT);

endmodule

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: issues tile starts under an in-flight limit, tracks retires,
// and reports completion or protocol/timeout errors.
module tile_seq_ctrl
    import tile_seq_pkg::*;
#(
    parameter int N_TILES_MAX = N_TILES_MAX_DEF,
    parameter int MAX_OUT     = MAX_OUT_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CNT_W       = $clog2(N_TILES_MAX + 1),
    localparam int OUT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_n_tiles,
    tile_seq_ctrl_if.master      tile,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [OUT_W-1:0]     outstanding
);

    seqState_e        state_q, state_d;
    logic [CNT_W-1:0] nTiles_q, nTiles_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             tvalid_q, tvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic tileFire;
    logic retire;
    logic inRun;
    logic startAcc;
    logic wdClear;
    logic wdEnable;
    logic wdExpire;

    assign tileFire = tvalid_q && tile.tile_TREADY;
    assign retire   = tile.y_fire;
    assign inRun    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign startAcc = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

    assign wdClear  = tileFire || retire || startAcc;
    assign wdEnable = inRun && (outst_q != '0);

    tile_seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wdClear),
        .enable (wdEnable),
        .expire (wdExpire)
    );

    // Next-state and counter updates; outputs are then decoded from the next state
    // so they leave the flops registered and never see tile_TREADY combinationally.
    always_comb begin
        state_d   = state_q;
        nTiles_d  = nTiles_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        outst_d   = outst_q;

        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    nTiles_d  = cfg_n_tiles;
                    issued_d  = '0;
                    retired_d = '0;
                    outst_d   = '0;
                    state_d   = (cfg_n_tiles == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (retire && (outst_q == '0)) begin
                    state_d = ST_ERR;
                end else if (wdExpire) begin
                    state_d = ST_ERR;
                end else begin
                    if (tileFire) begin
                        issued_d = issued_q + CNT_W'(1);
                    end
                    if (retire) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (tileFire && !retire) begin
                        outst_d = outst_q + OUT_W'(1);
                    end else if (!tileFire && retire) begin
                        outst_d = outst_q - OUT_W'(1);
                    end
                    if (retired_q == nTiles_q) begin
                        state_d = ST_DONE;
                    end else if ((state_q == ST_ISSUE) && tileFire && (issued_d == nTiles_q)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tvalid_d = (state_d == ST_ISSUE) && (issued_d < nTiles_d) && (outst_d < OUT_W'(MAX_OUT));
        busy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        err_d    = (state_d == ST_ERR);
        done_d   = (state_q == ST_DONE);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            nTiles_q  <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            outst_q   <= '0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nTiles_q  <= nTiles_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            outst_q   <= outst_d;
            tvalid_q  <= tvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tile.tile_TVALID = tvalid_q;
    assign tile.tile_TIDX   = issued_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign outstanding      = outst_q;

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Directed bench for tile_seq_ctrl: issue/retire flow, in-flight limit,
// backpressure, error entry/recovery, reset mid-run and empty runs.
module tb_tile_seq_ctrl;

    localparam int N_TILES_MAX = 64;
    localparam int MAX_OUT     = 4;
    localparam int TIMEOUT     = 64;
    localparam int CNT_W       = $clog2(N_TILES_MAX + 1);
    localparam int OUT_W       = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] cfgNTiles;
    logic             busy;
    logic             done;
    logic             err;
    logic [OUT_W-1:0] outstanding;

    int checkCount = 0;
    int failCount  = 0;
    int fireCount  = 0;
    int doneCount  = 0;
    int fireBase;
    int doneBase;

    tile_seq_ctrl_if #(.CNT_W(CNT_W)) tif ();

    tile_seq_ctrl #(
        .N_TILES_MAX (N_TILES_MAX),
        .MAX_OUT     (MAX_OUT),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_n_tiles (cfgNTiles),
        .tile        (tif),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .outstanding (outstanding)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, count the handshake taken at the coming edge,
    // then land on the following falling edge where outputs are sampled.
    task applyStimulus(input logic s, input int n, input logic tr, input logic yf);
        start            = s;
        cfgNTiles        = CNT_W'(n);
        tif.tile_TREADY  = tr;
        tif.y_fire       = yf;
        if (tif.tile_TVALID && tr) fireCount++;
        @(posedge clk);
        @(negedge clk);
        if (done) doneCount++;
    endtask

    initial begin
        start           = 1'b0;
        cfgNTiles       = '0;
        tif.tile_TREADY = 1'b0;
        tif.y_fire      = 1'b0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_tvalid", tif.tile_TVALID, 0);
        checkOutput("rst_tidx",   tif.tile_TIDX,   0);
        checkOutput("rst_busy",   busy,            0);
        checkOutput("rst_done",   done,            0);
        checkOutput("rst_err",    err,             0);
        checkOutput("rst_outst",  outstanding,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three tiles, always ready, each retired 20 cycles after its start.
        fireBase = fireCount;
        doneBase = doneCount;
        applyStimulus(1, 3, 1, 0);
        checkOutput("A_tvalid0", tif.tile_TVALID, 1);
        checkOutput("A_tidx0",   tif.tile_TIDX,   0);
        checkOutput("A_busy",    busy,            1);
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_tidx1",   tif.tile_TIDX,   1);
        checkOutput("A_outst1",  outstanding,     1);
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_tidx2",   tif.tile_TIDX,   2);
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_outst3",  outstanding,     3);
        checkOutput("A_tvalid_off", tif.tile_TVALID, 0);
        checkOutput("A_fires",   fireCount - fireBase, 3);
        for (int i = 0; i < 17; i++) applyStimulus(0, 3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3, 1, 1);
            checkOutput("A_outst_drain", outstanding, 2 - i);
        end
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_done_early", done, 0);
        checkOutput("A_busy_off",   busy, 0);
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_done_pulse", done, 1);
        applyStimulus(0, 3, 1, 0);
        checkOutput("A_done_end",   done, 0);
        checkOutput("A_done_count", doneCount - doneBase, 1);

        // Eight tiles with no retires: the in-flight limit stops issue at four.
        fireBase = fireCount;
        doneBase = doneCount;
        applyStimulus(1, 8, 1, 0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 8, 1, 0);
        checkOutput("B_fires_cap",  fireCount - fireBase, 4);
        checkOutput("B_tvalid_cap", tif.tile_TVALID, 0);
        checkOutput("B_outst_cap",  outstanding, 4);
        checkOutput("B_tidx_cap",   tif.tile_TIDX, 4);
        applyStimulus(0, 8, 1, 1);
        checkOutput("B_release_tvalid", tif.tile_TVALID, 1);
        checkOutput("B_release_outst",  outstanding, 3);
        applyStimulus(0, 8, 1, 0);
        checkOutput("B_refill_outst",  outstanding, 4);
        checkOutput("B_refill_tidx",   tif.tile_TIDX, 5);
        checkOutput("B_refill_tvalid", tif.tile_TVALID, 0);

        // Backpressure: request must hold steady while ready is low.
        applyStimulus(0, 8, 0, 1);
        checkOutput("C_tvalid_up", tif.tile_TVALID, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8, 0, 0);
            checkOutput("C_hold_tvalid", tif.tile_TVALID, 1);
            checkOutput("C_hold_tidx",   tif.tile_TIDX, 5);
        end
        applyStimulus(0, 8, 1, 1);
        checkOutput("C_sim_outst", outstanding, 3);
        checkOutput("C_sim_tidx",  tif.tile_TIDX, 6);
        applyStimulus(0, 8, 1, 1);
        applyStimulus(0, 8, 1, 1);
        checkOutput("C_last_tidx",   tif.tile_TIDX, 8);
        checkOutput("C_last_outst",  outstanding, 3);
        checkOutput("C_last_tvalid", tif.tile_TVALID, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8, 1, 1);
        checkOutput("C_outst_zero", outstanding, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8, 1, 0);
        checkOutput("C_done_count", doneCount - doneBase, 1);
        checkOutput("C_fire_total", fireCount - fireBase, 8);
        checkOutput("C_busy_off",   busy, 0);

        // Retire with nothing in flight, then recovery, then watchdog expiry.
        applyStimulus(1, 2, 0, 0);
        checkOutput("D_tvalid", tif.tile_TVALID, 1);
        applyStimulus(0, 2, 0, 1);
        checkOutput("D_err",        err, 1);
        checkOutput("D_err_tvalid", tif.tile_TVALID, 0);
        checkOutput("D_err_busy",   busy, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2, 1, 0);
        checkOutput("D_err_sticky", err, 1);
        applyStimulus(1, 2, 1, 0);
        checkOutput("D_restart_err",  err, 0);
        checkOutput("D_restart_tidx", tif.tile_TIDX, 0);
        checkOutput("D_restart_tvalid", tif.tile_TVALID, 1);
        applyStimulus(0, 2, 1, 0);
        applyStimulus(0, 2, 1, 0);
        checkOutput("D_wd_outst", outstanding, 2);
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 2, 1, 0);
        checkOutput("D_wd_before", err, 0);
        checkOutput("D_wd_busy",   busy, 1);
        applyStimulus(0, 2, 1, 0);
        checkOutput("D_wd_err",    err, 1);
        checkOutput("D_wd_tvalid", tif.tile_TVALID, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("D_rerun_err",  err, 0);
        checkOutput("D_rerun_tidx", tif.tile_TIDX, 0);
        checkOutput("D_rerun_outst", outstanding, 0);
        doneBase = doneCount;
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);
        checkOutput("D_rerun_done", doneCount - doneBase, 1);

        // Reset in the middle of draining.
        applyStimulus(1, 2, 1, 0);
        applyStimulus(0, 2, 1, 0);
        applyStimulus(0, 2, 1, 0);
        checkOutput("E_pre_outst", outstanding, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("E_rst_tvalid", tif.tile_TVALID, 0);
        checkOutput("E_rst_tidx",   tif.tile_TIDX, 0);
        checkOutput("E_rst_busy",   busy, 0);
        checkOutput("E_rst_done",   done, 0);
        checkOutput("E_rst_err",    err, 0);
        checkOutput("E_rst_outst",  outstanding, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneBase = doneCount;
        for (int i = 0; i < 5; i++) applyStimulus(0, 2, 1, 0);
        checkOutput("E_no_done",   doneCount - doneBase, 0);
        checkOutput("E_idle_tvalid", tif.tile_TVALID, 0);

        // Start while busy is ignored.
        applyStimulus(1, 2, 1, 0);
        applyStimulus(1, 5, 1, 0);
        checkOutput("E_ign_tidx",  tif.tile_TIDX, 1);
        applyStimulus(0, 5, 1, 0);
        checkOutput("E_ign_tvalid", tif.tile_TVALID, 0);
        checkOutput("E_ign_tidx2",  tif.tile_TIDX, 2);
        applyStimulus(0, 5, 1, 1);
        applyStimulus(0, 5, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 5, 1, 0);
        checkOutput("E_ign_done", doneCount - doneBase, 1);

        // Empty run: done two cycles after start, no tile request.
        fireBase = fireCount;
        applyStimulus(1, 0, 1, 0);
        checkOutput("F_done_c1",  done, 0);
        checkOutput("F_tvalid",   tif.tile_TVALID, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("F_done_c2",  done, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("F_done_c3",  done, 0);
        checkOutput("F_no_fire",  fireCount - fireBase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/tile_seq_ctrl.md
TILE_SEQ_CTRL -- requirements
Module: tile_seq_ctrl

Interface
REQ-001 SHALL have parameter N_TILES_MAX, default 64, meaning max tiles per run (D/TILE_SIZE).
REQ-002 SHALL have parameter MAX_OUT, default 4, meaning max tiles in flight (issued, not yet retired).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles with work in flight before error.
REQ-004 SHALL have parameter CNT_W, default $clog2(N_TILES_MAX+1), meaning counter width.
REQ-005 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have start  input  1  run request pulse.
REQ-008 SHALL have cfg_n_tiles  input  CNT_W  tiles to issue; latched on accepted start.
REQ-009 SHALL have tile_TVALID  output  1  tile-start request to the MAC datapath.
REQ-010 SHALL have tile_TREADY  input  1  datapath accepts tile start.
REQ-011 SHALL have tile_TIDX  output  CNT_W  index of the tile being requested.
REQ-012 SHALL have y_fire  input  1  gated output accepted (y valid and ready), one per tile.
REQ-013 SHALL have busy  output  1  high in ISSUE or DRAIN.
REQ-014 SHALL have done  output  1  one-cycle pulse when a run completes.
REQ-015 SHALL have err  output  1  sticky error flag.
REQ-016 SHALL have outstanding  output  $clog2(MAX_OUT+1)  tiles in flight.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, DRAIN, DONE and ERR.
REQ-018 SHALL accept start only in IDLE or ERR; start in ISSUE, DRAIN or DONE is ignored.
REQ-019 On an accepted start, SHALL latch cfg_n_tiles, clear the issued, retired and outstanding counters and err, and enter ISSUE next cycle, or DONE if cfg_n_tiles==0.
REQ-020 In ISSUE, SHALL drive tile_TVALID = (issued<n) && (outstanding<MAX_OUT), decoded from registers only, with no combinational path from tile_TREADY.
REQ-021 SHALL hold tile_TVALID and tile_TIDX stable once tile_TVALID is high, until tile_TREADY.
REQ-022 SHALL set tile_TIDX = issued, counting 0..n-1.
REQ-023 On tile fire (TVALID&&TREADY), SHALL increment issued and outstanding.
REQ-024 On y_fire, SHALL decrement outstanding and increment retired.
REQ-025 On a simultaneous tile fire and y_fire, SHALL leave outstanding unchanged and update both issued and retired.
REQ-026 SHALL move ISSUE->DRAIN on the fire that makes issued==n.
REQ-027 SHALL move DRAIN (or ISSUE) ->DONE in the cycle after retired reaches n.
REQ-028 In DONE, SHALL assert done for exactly one cycle, then go to IDLE.
REQ-029 On y_fire while outstanding==0, SHALL enter ERR next cycle.
REQ-030 SHALL run a watchdog that clears on any tile fire or y_fire, counts while outstanding>0 in ISSUE or DRAIN, and enters ERR when it reaches TIMEOUT-1.
REQ-031 In ERR, SHALL drive err=1, tile_TVALID=0 and busy=0, and stay there until start.
REQ-032 Latency: start accepted at edge t -> tile_TVALID high in cycle t+1 (n>0, outstanding 0).
REQ-033 Counters SHALL never wrap: issued<=n, retired<=issued, outstanding<=MAX_OUT.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, tile_TVALID=0, tile_TIDX=0, busy=0, done=0, err=0, outstanding=0, all counters and watchdog 0.
REQ-035 Reset mid-run SHALL abandon the run with no done pulse.
REQ-036 After reset release, the first action SHALL require a new start.

Structure
REQ-037 Package tile_seq_pkg SHALL hold the state enum typedef and the default values for N_TILES_MAX, MAX_OUT and TIMEOUT.
REQ-038 The watchdog SHALL be the single sub-module tile_seq_wdog (clear, enable, expire).

Verification
REQ-039 n=3, TREADY=1, y_fire 20 cycles after each tile fire -> TIDX 0,1,2 on consecutive cycles, outstanding peaks at 3, one done pulse after the 3rd y_fire, busy low afterwards.
REQ-040 n=8, MAX_OUT=4, no y_fire for 30 cycles -> exactly 4 fires, then tile_TVALID=0; each y_fire releases one further tile.
REQ-041 TREADY held low 5 cycles with TVALID high -> TVALID and TIDX stable throughout; simultaneous fire and y_fire -> outstanding unchanged.
REQ-042 y_fire with outstanding==0, or no y_fire for TIMEOUT cycles with outstanding=2 -> err=1, tile_TVALID=0; a subsequent start clears err and the run restarts at TIDX 0.
REQ-043 rst_n asserted mid-DRAIN -> all outputs 0 immediately, no done pulse; start during busy -> ignored; cfg_n_tiles=0 -> done two cycles after start, no tile fire.
